// File: rtl/reset_seq.sv
// ---------------------------------------------------------------------------
// reset_seq -- reset sequencer for the P1V core.
//
// Collects NSRC asynchronous reset request sources. Each source is
// synchronised, normalised to active-high and debounced. The debounced
// requests drive a three-state sequencer:
//   ACTIVE : at least one source is requesting reset
//   HOLD   : all sources released, reset is held for PULSE_CYC cycles
//   RUN    : core is out of reset
// On release of inp_resn the sequencer issues a full power-on hold pulse.
//
// Parameters:
//   NSRC      number of reset request sources (1..8)
//   POL       per-source polarity, bit=1 marks an active-low source
//   DEB_CYC   debounce length in clock cycles (>=1)
//   PULSE_CYC minimum reset hold after the last source releases (>=1)
//
// Ports:
//   clock     single clock, shared with the core
//   inp_resn  asynchronous active-low reset of the sequencer itself
//   src_in    raw asynchronous reset requests (button, Prop Plug RESn, ...)
//   cause_clr synchronous request to clear cause (honoured only in RUN)
//   res       registered active-high reset to the core
//   resn      registered complement of res
//   cause     sticky record of sources behind the current/last reset episode
// ---------------------------------------------------------------------------
module reset_seq #(
  parameter int              NSRC      = 2,
  parameter logic [NSRC-1:0] POL       = 2'b10,
  parameter int              DEB_CYC   = 1600,
  parameter int              PULSE_CYC = 8000000
) (
  input  logic            clock,
  input  logic            inp_resn,
  input  logic [NSRC-1:0] src_in,
  input  logic            cause_clr,
  output logic            res,
  output logic            resn,
  output logic [NSRC-1:0] cause
);

  localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC + 1) : 1;
  localparam int HW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC + 1) : 1;

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(PULSE_CYC - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(PULSE_CYC);

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_HOLD   = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  logic [NSRC-1:0] r_sync1;
  logic [NSRC-1:0] r_sync2;
  logic [NSRC-1:0] r_filt;
  logic [DW-1:0]   r_deb_cnt [NSRC];

  state_t          r_state;
  logic [HW-1:0]   r_hold_cnt;
  logic            r_res;
  logic            r_resn;
  logic [NSRC-1:0] r_cause;

  logic [NSRC-1:0] w_req;
  logic            w_any_filt;

  // Saturating increment: the hold counter must never wrap back to zero.
  function automatic logic [HW-1:0] hold_inc(input logic [HW-1:0] c);
    return (c == HOLD_MAX) ? c : (c + HW'(1));
  endfunction

  // Synchronised raw level XOR polarity gives an active-high request.
  assign w_req      = r_sync2 ^ POL;
  assign w_any_filt = |r_filt;

  // Per-source 2-flop synchroniser and debounce filter.
  always_ff @(posedge clock or negedge inp_resn) begin
    if (!inp_resn) begin
      // Synchroniser idles at each source's inactive raw level (= POL bit).
      r_sync1 <= POL;
      r_sync2 <= POL;
      r_filt  <= '0;
      for (int i = 0; i < NSRC; i++) begin
        r_deb_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= src_in;
      r_sync2 <= r_sync1;
      for (int i = 0; i < NSRC; i++) begin
        if (w_req[i] != r_filt[i]) begin
          // DEB_CYC-th consecutive differing cycle: adopt the new level.
          if (r_deb_cnt[i] == DEB_LAST) begin
            r_filt[i]    <= w_req[i];
            r_deb_cnt[i] <= '0;
          end else begin
            r_deb_cnt[i] <= r_deb_cnt[i] + DW'(1);
          end
        end else begin
          r_deb_cnt[i] <= '0;
        end
      end
    end
  end

  // Sequencer FSM; res/resn are registered from the next state.
  always_ff @(posedge clock or negedge inp_resn) begin
    if (!inp_resn) begin
      r_state    <= ST_ACTIVE;
      r_hold_cnt <= '0;
      r_res      <= 1'b1;
      r_resn     <= 1'b0;
      r_cause    <= '0;
    end else begin
      case (r_state)
        ST_ACTIVE: begin
          r_cause <= r_cause | r_filt;
          r_res   <= 1'b1;
          r_resn  <= 1'b0;
          if (!w_any_filt) begin
            r_state    <= ST_HOLD;
            r_hold_cnt <= '0;
          end else begin
            r_state    <= ST_ACTIVE;
          end
        end
        ST_HOLD: begin
          r_cause <= r_cause | r_filt;
          if (w_any_filt) begin
            // A new request restarts the whole episode.
            r_state    <= ST_ACTIVE;
            r_hold_cnt <= '0;
            r_res      <= 1'b1;
            r_resn     <= 1'b0;
          end else if (r_hold_cnt == HOLD_LAST) begin
            r_state    <= ST_RUN;
            r_hold_cnt <= hold_inc(r_hold_cnt);
            r_res      <= 1'b0;
            r_resn     <= 1'b1;
          end else begin
            r_state    <= ST_HOLD;
            r_hold_cnt <= hold_inc(r_hold_cnt);
            r_res      <= 1'b1;
            r_resn     <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_any_filt) begin
            // New episode: cause restarts from the current requests; this
            // load wins over a simultaneous cause_clr.
            r_state <= ST_ACTIVE;
            r_cause <= r_filt;
            r_res   <= 1'b1;
            r_resn  <= 1'b0;
          end else if (cause_clr) begin
            r_state <= ST_RUN;
            r_cause <= '0;
            r_res   <= 1'b0;
            r_resn  <= 1'b1;
          end else begin
            r_state <= ST_RUN;
            r_res   <= 1'b0;
            r_resn  <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_ACTIVE;
          r_hold_cnt <= '0;
          r_res      <= 1'b1;
          r_resn     <= 1'b0;
        end
      endcase
    end
  end

  assign res   = r_res;
  assign resn  = r_resn;
  assign cause = r_cause;

endmodule

// File: tb/tb_reset_seq.sv
// ---------------------------------------------------------------------------
// tb_reset_seq -- directed self-checking bench for reset_seq with
// NSRC=2, POL=2'b10, DEB_CYC=4, PULSE_CYC=10.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// Timing reference: a source first sampled on edge 1 sets filt on edge 6
// and res on edge 7; after release the FSM enters HOLD one edge after filt
// clears, so res falls 1 + 10 edges after filt clears (17 after src release,
// 11 after inp_resn release).
// ---------------------------------------------------------------------------
module tb_reset_seq;

  logic       clock;
  logic       inp_resn;
  logic [1:0] src_in;
  logic       cause_clr;
  logic       res;
  logic       resn;
  logic [1:0] cause;

  int n_tests = 0;
  int n_fail  = 0;
  int n_cyc;
  int n_bad;

  reset_seq #(
    .NSRC      (2),
    .POL       (2'b10),
    .DEB_CYC   (4),
    .PULSE_CYC (10)
  ) dut (
    .clock     (clock),
    .inp_resn  (inp_resn),
    .src_in    (src_in),
    .cause_clr (cause_clr),
    .res       (res),
    .resn      (resn),
    .cause     (cause)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count one comparison and report it if the observed value differs.
  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
    end
  endtask

  // Edges until res reaches the wanted level; returns 200 on timeout.
  task automatic count_until(input logic want, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while ((res !== want) && (n < 200));
  endtask

  initial begin
    inp_resn  = 1'b0;
    src_in    = 2'b10;
    cause_clr = 1'b0;
    tick_n(3);

    // Reset state
    check_eq("rst_res",   int'(res),   1);
    check_eq("rst_resn",  int'(resn),  0);
    check_eq("rst_cause", int'(cause), 0);

    // Power-on pulse
    inp_resn = 1'b1;
    count_until(1'b0, n_cyc);
    check_eq("por_len",   n_cyc,       11);
    check_eq("por_resn",  int'(resn),  1);
    check_eq("por_cause", int'(cause), 0);

    // Button on src_in[0] held for 20 cycles
    src_in = 2'b11;
    count_until(1'b1, n_cyc);
    check_eq("btn_rise",  n_cyc,       7);
    tick_n(13);
    check_eq("btn_cause", int'(cause), 1);
    src_in = 2'b10;
    count_until(1'b0, n_cyc);
    check_eq("btn_fall",  n_cyc,       17);
    check_eq("btn_cause_sticky", int'(cause), 1);

    // 3-cycle glitch on active-low src_in[1]
    n_bad = 0;
    src_in = 2'b00;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (res !== 1'b0) n_bad++;
    end
    src_in = 2'b10;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (res !== 1'b0) n_bad++;
    end
    check_eq("glitch_res",   n_bad,       0);
    check_eq("glitch_cause", int'(cause), 1);

    // Retrigger: src_in[1] asserts so the FSM sees filt[1] at HOLD count 6
    src_in = 2'b11;
    count_until(1'b1, n_cyc);
    check_eq("retrig_rise", n_cyc, 7);
    src_in = 2'b10;
    tick_n(7);
    src_in = 2'b00;
    tick_n(10);
    check_eq("retrig_held",  int'(res),   1);
    check_eq("retrig_cause", int'(cause), 3);
    src_in = 2'b10;
    count_until(1'b0, n_cyc);
    check_eq("retrig_fall",  n_cyc,       17);

    // Clear race: cause_clr in the cycle the FSM first sees filt[1]
    src_in = 2'b00;
    tick_n(6);
    cause_clr = 1'b1;
    tick();
    cause_clr = 1'b0;
    check_eq("race_res",   int'(res),   1);
    check_eq("race_cause", int'(cause), 2);
    cause_clr = 1'b1;
    tick();
    cause_clr = 1'b0;
    check_eq("clr_in_active", int'(cause), 2);
    src_in = 2'b10;
    count_until(1'b0, n_cyc);
    check_eq("race_fall", n_cyc, 17);
    cause_clr = 1'b1;
    tick();
    cause_clr = 1'b0;
    check_eq("clr_in_run", int'(cause), 0);

    // Mid-operation reset at HOLD count 5
    src_in = 2'b11;
    count_until(1'b1, n_cyc);
    src_in = 2'b10;
    tick_n(12);
    check_eq("mid_pre_res",   int'(res),   1);
    check_eq("mid_pre_cause", int'(cause), 1);
    inp_resn = 1'b0;
    #1;
    check_eq("mid_async_res",   int'(res),   1);
    check_eq("mid_async_resn",  int'(resn),  0);
    check_eq("mid_async_cause", int'(cause), 0);
    tick_n(3);
    inp_resn = 1'b1;
    count_until(1'b0, n_cyc);
    check_eq("mid_por_len",   n_cyc,       11);
    check_eq("mid_por_resn",  int'(resn),  1);
    check_eq("mid_por_cause", int'(cause), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
